// File: rtl/cpu_sequencer.sv
// Multi-cycle MIPS control sequencer: owns the PC, the instruction register and the
// shared Avalon port, with branch delay slots and halt on a jump to HALT_ADDR.
module cpu_sequencer #(
   parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
   parameter logic [31:0] HALT_ADDR    = 32'h00000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        clk_enable,
   input  logic        avm_waitrequest,
   input  logic [31:0] avm_readdata,
   output logic [31:0] avm_address,
   output logic        avm_read,
   output logic        avm_write,
   output logic [3:0]  avm_byteenable,
   input  logic [1:0]  pc_sel,
   input  logic        dec_data_read,
   input  logic        dec_data_write,
   input  logic [3:0]  dec_byte_enable,
   input  logic        dec_reg_write,
   input  logic        branch_taken,
   input  logic [31:0] rs_data,
   input  logic [31:0] data_addr,
   output logic [31:0] instr,
   output logic [31:0] pc,
   output logic [31:0] load_data,
   output logic        reg_write_en,
   output logic        active
);
   localparam int unsigned XLEN = 32;
   localparam int unsigned BEW  = 4;

   typedef enum logic [2:0] {
      S_FETCH,
      S_EXEC,
      S_MEM,
      S_COMMIT,
      S_HALTED
   } state_e;

   state_e            state_q, state_d;
   logic [XLEN-1:0]   pc_q, pc_d;
   logic [XLEN-1:0]   instr_q, instr_d;
   logic [XLEN-1:0]   load_q, load_d;
   logic [XLEN-1:0]   target_q, target_d;
   logic              pending_q, pending_d;
   logic              active_q, active_d;

   logic [XLEN-1:0]   pc_plus4;
   logic [XLEN-1:0]   branch_off;
   logic [XLEN-1:0]   next_pc;

   assign pc_plus4   = pc_q + XLEN'(4);
   assign branch_off = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

   // State and architectural registers; clk_enable low freezes everything.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_FETCH;
         pc_q      <= RESET_VECTOR;
         instr_q   <= '0;
         load_q    <= '0;
         target_q  <= '0;
         pending_q <= 1'b0;
         active_q  <= 1'b0;
      end else if (clk_enable) begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         instr_q   <= instr_d;
         load_q    <= load_d;
         target_q  <= target_d;
         pending_q <= pending_d;
         active_q  <= active_d;
      end
   end

   // Next-state, bus strobes and commit logic.
   always_comb begin
      state_d        = state_q;
      pc_d           = pc_q;
      instr_d        = instr_q;
      load_d         = load_q;
      target_d       = target_q;
      pending_d      = pending_q;
      active_d       = active_q;
      next_pc        = pending_q ? target_q : pc_plus4;
      avm_address    = pc_q;
      avm_read       = 1'b0;
      avm_write      = 1'b0;
      avm_byteenable = '0;
      reg_write_en   = 1'b0;

      // The first edge after reset only raises active; fetching starts the cycle after.
      if (!active_q && state_q != S_HALTED) begin
         active_d = 1'b1;
      end

      case (state_q)
         S_FETCH: begin
            if (active_q) begin
               avm_read       = 1'b1;
               avm_byteenable = {BEW{1'b1}};
               if (!avm_waitrequest) begin
                  instr_d = avm_readdata;
                  state_d = S_EXEC;
               end
            end
         end
         S_EXEC: begin
            state_d = (dec_data_write || dec_data_read) ? S_MEM : S_COMMIT;
         end
         S_MEM: begin
            avm_address    = data_addr;
            avm_byteenable = dec_byte_enable;
            avm_write      = dec_data_write;
            avm_read       = dec_data_read && !dec_data_write;
            if (!avm_waitrequest) begin
               if (!dec_data_write) begin
                  load_d = avm_readdata;
               end
               state_d = S_COMMIT;
            end
         end
         S_COMMIT: begin
            reg_write_en = dec_reg_write;
            pc_d         = next_pc;
            pending_d    = 1'b0;
            // Control transfers in a delay slot are dropped.
            if (!pending_q) begin
               case (pc_sel)
                  2'b01: begin
                     if (branch_taken) begin
                        pending_d = 1'b1;
                        target_d  = pc_plus4 + branch_off;
                     end
                  end
                  2'b10: begin
                     pending_d = 1'b1;
                     target_d  = {pc_plus4[31:28], instr_q[25:0], 2'b00};
                  end
                  2'b11: begin
                     pending_d = 1'b1;
                     target_d  = rs_data;
                  end
                  default: ;
               endcase
            end
            if (next_pc == HALT_ADDR) begin
               state_d  = S_HALTED;
               active_d = 1'b0;
            end else begin
               state_d = S_FETCH;
            end
         end
         S_HALTED: begin
            active_d = 1'b0;
         end
         default: begin
            state_d = S_FETCH;
         end
      endcase
   end

   assign instr     = instr_q;
   assign pc        = pc_q;
   assign load_data = load_q;
   assign active    = active_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: per-cycle vector table plus hand-written reset sequences.
module tb_cpu_sequencer;
   localparam logic        H   = 1'b1;
   localparam logic        L   = 1'b0;
   localparam logic [1:0]  PS0 = 2'd0;
   localparam logic [1:0]  PSB = 2'd1;
   localparam logic [1:0]  PSJ = 2'd2;
   localparam logic [1:0]  PSR = 2'd3;
   localparam logic [3:0]  B0  = 4'h0;
   localparam logic [3:0]  B3  = 4'h3;
   localparam logic [3:0]  BF  = 4'hF;
   localparam logic [31:0] Z   = 32'h0;
   localparam logic [31:0] RV  = 32'hBFC00000;
   localparam logic [31:0] DB  = 32'hDEADBEEF;
   localparam logic [31:0] JK  = 32'hEEEEEEEE;

   localparam logic [31:0] I_ADDU  = 32'h00221821;
   localparam logic [31:0] I_LW    = 32'h8C220000;
   localparam logic [31:0] I_SW    = 32'hAC220004;
   localparam logic [31:0] I_JR    = 32'h00200008;
   localparam logic [31:0] I_JDS   = 32'h08000040;
   localparam logic [31:0] I_BEQ   = 32'h10220004;
   localparam logic [31:0] I_BNE   = 32'h1422FFFE;
   localparam logic [31:0] I_J400  = 32'h08000100;
   localparam logic [31:0] I_ADDIU = 32'h24210001;
   localparam logic [31:0] I_NOP   = 32'h00000000;

   typedef struct {
      logic [1:0]  psel;
      logic        bt;
      logic        dr;
      logic        dw;
      logic [3:0]  dbe;
      logic        rw;
      logic [31:0] rs;
      logic [31:0] daddr;
   } dec_t;

   typedef struct {
      logic        en;
      logic        wt;
      logic [31:0] rdata;
      dec_t        d;
      logic        x_rd;
      logic        x_wr;
      logic [31:0] x_addr;
      logic [3:0]  x_be;
      logic        x_rwe;
      logic        x_act;
      logic [31:0] x_pc;
      logic [31:0] x_ld;
   } vec_t;

   localparam dec_t D_ALU  = '{PS0, L, L, L, B0, H, Z, Z};
   localparam dec_t D_NOP  = '{PS0, L, L, L, B0, L, Z, Z};
   localparam dec_t D_LW   = '{PS0, L, H, L, BF, H, Z, 32'h00001000};
   localparam dec_t D_SW   = '{PS0, L, H, H, B3, L, Z, 32'h00002004};
   localparam dec_t D_SW2  = '{PS0, L, L, H, BF, L, Z, 32'h00002000};
   localparam dec_t D_JR1  = '{PSR, L, L, L, B0, L, 32'h00000100, Z};
   localparam dec_t D_JR3  = '{PSR, L, L, L, B0, L, 32'h00000300, Z};
   localparam dec_t D_JR0  = '{PSR, L, L, L, B0, L, Z, Z};
   localparam dec_t D_J    = '{PSJ, L, L, L, B0, L, Z, Z};
   localparam dec_t D_BT   = '{PSB, H, L, L, B0, L, Z, Z};
   localparam dec_t D_BN   = '{PSB, L, L, L, B0, L, Z, Z};

   logic        clk;
   logic        reset;
   logic        clk_enable;
   logic        avm_waitrequest;
   logic [31:0] avm_readdata;
   logic [31:0] avm_address;
   logic        avm_read;
   logic        avm_write;
   logic [3:0]  avm_byteenable;
   logic [1:0]  pc_sel;
   logic        dec_data_read;
   logic        dec_data_write;
   logic [3:0]  dec_byte_enable;
   logic        dec_reg_write;
   logic        branch_taken;
   logic [31:0] rs_data;
   logic [31:0] data_addr;
   logic [31:0] instr;
   logic [31:0] pc;
   logic [31:0] load_data;
   logic        reg_write_en;
   logic        active;

   int checks = 0;
   int errors = 0;
   vec_t tbl[$];

   cpu_sequencer dut (
      .clk             (clk),
      .reset           (reset),
      .clk_enable      (clk_enable),
      .avm_waitrequest (avm_waitrequest),
      .avm_readdata    (avm_readdata),
      .avm_address     (avm_address),
      .avm_read        (avm_read),
      .avm_write       (avm_write),
      .avm_byteenable  (avm_byteenable),
      .pc_sel          (pc_sel),
      .dec_data_read   (dec_data_read),
      .dec_data_write  (dec_data_write),
      .dec_byte_enable (dec_byte_enable),
      .dec_reg_write   (dec_reg_write),
      .branch_taken    (branch_taken),
      .rs_data         (rs_data),
      .data_addr       (data_addr),
      .instr           (instr),
      .pc              (pc),
      .load_data       (load_data),
      .reg_write_en    (reg_write_en),
      .active          (active)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h required %h", nm, got, exp);
      end
   endtask

   task automatic apply(input vec_t v);
      clk_enable      = v.en;
      avm_waitrequest = v.wt;
      avm_readdata    = v.rdata;
      pc_sel          = v.d.psel;
      branch_taken    = v.d.bt;
      dec_data_read   = v.d.dr;
      dec_data_write  = v.d.dw;
      dec_byte_enable = v.d.dbe;
      dec_reg_write   = v.d.rw;
      rs_data         = v.d.rs;
      data_addr       = v.d.daddr;
   endtask

   // One cycle: drive just after the rising edge, sample at the falling edge.
   task automatic step(input vec_t v, input string tag);
      @(posedge clk);
      #1;
      apply(v);
      @(negedge clk);
      chk({tag, " read"},   32'(avm_read),     32'(v.x_rd));
      chk({tag, " write"},  32'(avm_write),    32'(v.x_wr));
      chk({tag, " rwe"},    32'(reg_write_en), 32'(v.x_rwe));
      chk({tag, " active"}, 32'(active),       32'(v.x_act));
      chk({tag, " pc"},     pc,                v.x_pc);
      chk({tag, " ldata"},  load_data,         v.x_ld);
      if (v.x_rd || v.x_wr) begin
         chk({tag, " addr"}, avm_address,           v.x_addr);
         chk({tag, " be"},   32'(avm_byteenable),   32'(v.x_be));
      end
   endtask

   // FETCH / EXEC / COMMIT rows for a zero-wait non-memory instruction.
   task automatic add_simple(input logic [31:0] a, input logic [31:0] ins, input dec_t d,
                             input logic rwe, input logic [31:0] ld);
      tbl.push_back(vec_t'{H, L, ins, d, H, L, a, BF, L,   H, a, ld});
      tbl.push_back(vec_t'{H, L, JK,  d, L, L, a, B0, L,   H, a, ld});
      tbl.push_back(vec_t'{H, L, JK,  d, L, L, a, B0, rwe, H, a, ld});
   endtask

   task automatic do_reset();
      reset = 1'b0;
      apply(vec_t'{H, L, Z, D_NOP, L, L, Z, B0, L, L, RV, Z});
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst read",   32'(avm_read),     32'h0);
      chk("rst write",  32'(avm_write),    32'h0);
      chk("rst rwe",    32'(reg_write_en), 32'h0);
      chk("rst active", 32'(active),       32'h0);
      chk("rst pc",     pc,                RV);
      chk("rst instr",  instr,             Z);
      chk("rst ldata",  load_data,         Z);
      reset = 1'b1;
      #1;
      chk("rel read",   32'(avm_read),     32'h0);
      chk("rel active", 32'(active),       32'h0);
   endtask

   initial begin
      // ADDU, LW with fetch and memory waits, SW with both data flags set.
      add_simple(RV, I_ADDU, D_ALU, H, Z);
      repeat (3) tbl.push_back(vec_t'{H, H, JK, D_LW, H, L, 32'hBFC00004, BF, L, H, 32'hBFC00004, Z});
      tbl.push_back(vec_t'{H, L, I_LW, D_LW, H, L, 32'hBFC00004, BF, L, H, 32'hBFC00004, Z});
      tbl.push_back(vec_t'{H, L, JK,   D_LW, L, L, 32'hBFC00004, B0, L, H, 32'hBFC00004, Z});
      repeat (2) tbl.push_back(vec_t'{H, H, JK, D_LW, H, L, 32'h00001000, BF, L, H, 32'hBFC00004, Z});
      tbl.push_back(vec_t'{H, L, DB, D_LW, H, L, 32'h00001000, BF, L, H, 32'hBFC00004, Z});
      tbl.push_back(vec_t'{H, L, JK, D_LW, L, L, 32'hBFC00004, B0, H, H, 32'hBFC00004, DB});
      tbl.push_back(vec_t'{H, L, I_SW,         D_SW, H, L, 32'hBFC00008, BF, L, H, 32'hBFC00008, DB});
      tbl.push_back(vec_t'{H, L, JK,           D_SW, L, L, 32'hBFC00008, B0, L, H, 32'hBFC00008, DB});
      tbl.push_back(vec_t'{H, L, 32'h12345678, D_SW, L, H, 32'h00002004, B3, L, H, 32'hBFC00008, DB});
      tbl.push_back(vec_t'{H, L, JK,           D_SW, L, L, 32'hBFC00008, B0, L, H, 32'hBFC00008, DB});
      // JR to 0x100 whose delay slot holds a J that must be ignored.
      add_simple(32'hBFC0000C, I_JR,  D_JR1, L, DB);
      add_simple(32'hBFC00010, I_JDS, D_J,   L, DB);
      // Taken BEQ (+4 words), untaken BEQ, taken BNE (-2 words).
      add_simple(32'h00000100, I_BEQ, D_BT,  L, DB);
      add_simple(32'h00000104, I_NOP, D_NOP, L, DB);
      add_simple(32'h00000114, I_BEQ, D_BN,  L, DB);
      add_simple(32'h00000118, I_NOP, D_NOP, L, DB);
      add_simple(32'h0000011C, I_BNE, D_BT,  L, DB);
      add_simple(32'h00000120, I_NOP, D_NOP, L, DB);
      // Two frozen cycles mid-fetch, then J to 0x400.
      repeat (2) tbl.push_back(vec_t'{L, L, I_J400, D_J, H, L, 32'h00000118, BF, L, H, 32'h00000118, DB});
      add_simple(32'h00000118, I_J400, D_J,   L, DB);
      add_simple(32'h0000011C, I_NOP,  D_NOP, L, DB);
      // JR to 0 with an ADDIU delay slot, then halted.
      add_simple(32'h00000400, I_JR,    D_JR0, L, DB);
      add_simple(32'h00000404, I_ADDIU, D_ALU, H, DB);
      repeat (2) tbl.push_back(vec_t'{H, L, I_ADDIU, D_ALU, L, L, Z, B0, L, L, Z, DB});

      do_reset();
      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i], $sformatf("v%0d", i));
      end
      chk("halt instr", instr, I_ADDIU);

      // Reset during a stalled store in a delay slot: strobe drops, pending is lost.
      do_reset();
      add_simple(RV, I_JR, D_JR3, L, Z);
      for (int i = tbl.size() - 3; i < tbl.size(); i++) begin
         step(tbl[i], $sformatf("s%0d", i));
      end
      step(vec_t'{H, L, I_SW, D_SW2, H, L, 32'hBFC00004, BF, L, H, 32'hBFC00004, Z}, "m0");
      step(vec_t'{H, L, JK,   D_SW2, L, L, 32'hBFC00004, B0, L, H, 32'hBFC00004, Z}, "m1");
      step(vec_t'{H, H, JK,   D_SW2, L, H, 32'h00002000, BF, L, H, 32'hBFC00004, Z}, "m2");
      #2;
      reset = 1'b0;
      #1;
      chk("async write", 32'(avm_write),    32'h0);
      chk("async read",  32'(avm_read),     32'h0);
      chk("async rwe",   32'(reg_write_en), 32'h0);
      chk("async pc",    pc,                RV);
      @(negedge clk);
      reset = 1'b1;
      step(vec_t'{H, L, I_NOP, D_NOP, H, L, RV, BF, L, H, RV, Z}, "r0");
      step(vec_t'{H, L, JK,    D_NOP, L, L, RV, B0, L, H, RV, Z}, "r1");
      step(vec_t'{H, L, JK,    D_NOP, L, L, RV, B0, L, H, RV, Z}, "r2");
      step(vec_t'{H, H, JK,    D_NOP, H, L, 32'hBFC00004, BF, L, H, 32'hBFC00004, Z}, "r3");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
